text_renderer: RTL and testbench

Text-mode pixel pipeline between the video BSRAM read port and the 480x272 LCD pins. It generates the panel scan counters and fetches character codes from the BSRAM text buffer (60 columns x 17 rows, 8x16 glyphs). It looks each code up in an external font ROM and drives LCD_DE and RGB565-style colour pins. The BSRAM read port (adb/ceb/dout, oce tied high) is owned exclusively by this block; the write port stays with the CPU side.

---
 rtl/text_renderer_if.sv | 24 ++
 rtl/text_renderer.sv | 116 +++++++++++
 tb/tb_text_renderer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/text_renderer_if.sv
// Video-memory, font-ROM and LCD pin bundle of the text renderer.
// master = renderer side, slave = memories / panel side.
interface text_renderer_if;
   logic [12:0] vram_adb;
   logic        vram_ceb;
   logic [7:0]  vram_dout;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic        LCD_DE;
   logic [4:0]  LCD_R;
   logic [5:0]  LCD_G;
   logic [4:0]  LCD_B;
   logic        frame_start;

   modport master (
      output vram_adb, vram_ceb, font_addr, LCD_DE, LCD_R, LCD_G, LCD_B, frame_start,
      input  vram_dout, font_data
   );

   modport slave (
      input  vram_adb, vram_ceb, font_addr, LCD_DE, LCD_R, LCD_G, LCD_B, frame_start,
      output vram_dout, font_data
   );
endinterface

// File: rtl/text_renderer.sv
// Text-mode LCD pixel pipeline: scan counters, character fetch from BSRAM,
// glyph lookup in an external font ROM and registered RGB565 pin drive.
module text_renderer #(
   parameter int unsigned H_ACTIVE  = 480,
   parameter int unsigned H_BP      = 43,
   parameter int unsigned H_FP      = 8,
   parameter int unsigned V_ACTIVE  = 272,
   parameter int unsigned V_BP      = 12,
   parameter int unsigned V_FP      = 8,
   parameter logic [12:0] BASE_ADDR = 13'h0200,
   parameter logic [15:0] FG        = 16'hFFFF,
   parameter logic [15:0] BG        = 16'h0000
) (
   input  logic            PixelClk,
   input  logic            nRST,
   text_renderer_if.master bus
);

   localparam int unsigned H_TOTAL = H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_BP + V_ACTIVE + V_FP;
   localparam int unsigned HCW     = $clog2(H_TOTAL);
   localparam int unsigned VCW     = $clog2(V_TOTAL);
   localparam int unsigned COLS    = H_ACTIVE / 8;

   logic [HCW-1:0] r_hcnt;
   logic [VCW-1:0] r_vcnt;

   logic           w_h_last;
   logic           w_v_last;
   logic           w_active;
   logic [HCW-1:0] w_x;
   logic [VCW-1:0] w_y;
   logic [12:0]    w_addr;
   logic           w_pix;

   // Stage 1..3 alignment registers (stage 1 active flag is r_ceb)
   logic [12:0]    r_adb;
   logic           r_ceb;
   logic           r_fs;
   logic [3:0]     r_y_s1;
   logic [3:0]     r_y_s2;
   logic [2:0]     r_x_s1;
   logic [2:0]     r_x_s2;
   logic [2:0]     r_x_s3;
   logic           r_act_s2;
   logic           r_act_s3;
   logic           r_de;
   logic [15:0]    r_rgb;

   assign w_h_last = (r_hcnt == HCW'(H_TOTAL - 1));
   assign w_v_last = (r_vcnt == VCW'(V_TOTAL - 1));
   assign w_active = (r_hcnt >= HCW'(H_BP)) && (r_hcnt < HCW'(H_BP + H_ACTIVE)) &&
                     (r_vcnt >= VCW'(V_BP)) && (r_vcnt < VCW'(V_BP + V_ACTIVE));
   assign w_x      = r_hcnt - HCW'(H_BP);
   assign w_y      = r_vcnt - VCW'(V_BP);
   assign w_addr   = BASE_ADDR + 13'(w_y[VCW-1:4]) * 13'(COLS) + 13'(w_x[HCW-1:3]);
   assign w_pix    = bus.font_data[3'd7 - r_x_s3];

   // Panel scan counters
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (w_h_last) begin
         r_hcnt <= '0;
         r_vcnt <= w_v_last ? '0 : r_vcnt + VCW'(1);
      end else begin
         r_hcnt <= r_hcnt + HCW'(1);
      end
   end

   // Fetch address, then delay x/y/active to meet the 1-cycle memory returns
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         r_adb    <= '0;
         r_ceb    <= 1'b0;
         r_fs     <= 1'b0;
         r_y_s1   <= '0;
         r_y_s2   <= '0;
         r_x_s1   <= '0;
         r_x_s2   <= '0;
         r_x_s3   <= '0;
         r_act_s2 <= 1'b0;
         r_act_s3 <= 1'b0;
         r_de     <= 1'b0;
         r_rgb    <= '0;
      end else begin
         if (w_active) begin
            r_adb <= w_addr;
         end
         r_ceb    <= w_active;
         r_fs     <= (r_hcnt == '0) && (r_vcnt == '0);
         r_y_s1   <= w_y[3:0];
         r_y_s2   <= r_y_s1;
         r_x_s1   <= w_x[2:0];
         r_x_s2   <= r_x_s1;
         r_x_s3   <= r_x_s2;
         r_act_s2 <= r_ceb;
         r_act_s3 <= r_act_s2;
         r_de     <= r_act_s3;
         r_rgb    <= r_act_s3 ? (w_pix ? FG : BG) : 16'h0000;
      end
   end

   // Font address is formed directly from the BSRAM data so the ROM read
   // overlaps the next cycle without an extra pipeline stage.
   assign bus.font_addr   = {bus.vram_dout, r_y_s2};
   assign bus.vram_adb    = r_adb;
   assign bus.vram_ceb    = r_ceb;
   assign bus.frame_start = r_fs;
   assign bus.LCD_DE      = r_de;
   assign bus.LCD_R       = r_rgb[15:11];
   assign bus.LCD_G       = r_rgb[10:5];
   assign bus.LCD_B       = r_rgb[4:0];

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: a full-size instance against a
// scan-position model, plus a shrunken-timing instance for frame/colour checks.
module tb_text_renderer;

   localparam int H_TOT  = 531;
   localparam int V_TOT  = 292;
   localparam int FRAME  = H_TOT * V_TOT;
   localparam int SFRAME = 40 * 36;

   logic PixelClk = 1'b0;
   logic nRST     = 1'b0;
   always #5 PixelClk = ~PixelClk;

   text_renderer_if u_if ();
   text_renderer_if u_ifs ();

   text_renderer u_dut (
      .PixelClk (PixelClk),
      .nRST     (nRST),
      .bus      (u_if.master)
   );

   text_renderer #(
      .H_ACTIVE (32), .H_BP (5), .H_FP (3),
      .V_ACTIVE (32), .V_BP (2), .V_FP (2),
      .FG (16'hF800), .BG (16'h001F)
   ) u_small (
      .PixelClk (PixelClk),
      .nRST     (nRST),
      .bus      (u_ifs.master)
   );

   logic [7:0] vram [8192];
   logic [7:0] font_mem [4096];
   logic [7:0] vdout, fdata, vdout_s;

   // 1-cycle-latency BSRAM read port and font ROM
   always @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         vdout   <= 8'h00;
         fdata   <= 8'h00;
         vdout_s <= 8'h00;
      end else begin
         if (u_if.vram_ceb) vdout <= vram[u_if.vram_adb];
         fdata <= font_mem[u_if.font_addr];
         if (u_ifs.vram_ceb) vdout_s <= vram[u_ifs.vram_adb];
      end
   end
   assign u_if.vram_dout  = vdout;
   assign u_if.font_data  = fdata;
   assign u_ifs.vram_dout = vdout_s;
   assign u_ifs.font_data = 8'hFF;

   int total = 0;
   int bad   = 0;
   int n;

   // n = index of the most recent rising edge since reset release (first edge = 0)
   always @(posedge PixelClk or negedge nRST) begin
      if (!nRST) n <= -1;
      else       n <= n + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at n=%0d: got=%0h expected=%0h", name, n, got, exp);
      end
   endtask

   // Scan-position model of the full-size panel
   function automatic bit m_act(input int c);
      int h = c % H_TOT;
      int v = (c / H_TOT) % V_TOT;
      return (h >= 43) && (h < 523) && (v >= 12) && (v < 284);
   endfunction

   function automatic int m_addr(input int c);
      int h = c % H_TOT;
      int v = (c / H_TOT) % V_TOT;
      return 'h200 + ((v - 12) / 16) * 60 + (h - 43) / 8;
   endfunction

   function automatic int m_fa(input int c);
      int v = (c / H_TOT) % V_TOT;
      return int'(vram[m_addr(c)]) * 16 + (v - 12) % 16;
   endfunction

   function automatic int m_rgb(input int c);
      int h     = c % H_TOT;
      int glyph = int'(font_mem[m_fa(c)]);
      int bitn  = 7 - ((h - 43) % 8);
      return ((glyph >> bitn) & 1) != 0 ? 'hFFFF : 'h0000;
   endfunction

   logic [15:0] glyph_exp [8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                                  16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

   int exp_adb, run, s_run, s_lines, last_fs_s;
   bit prev_de, s_prev_de;

   always @(negedge PixelClk) begin
      int c, sc;
      logic [15:0] rgb, srgb;
      rgb  = {u_if.LCD_R, u_if.LCD_G, u_if.LCD_B};
      srgb = {u_ifs.LCD_R, u_ifs.LCD_G, u_ifs.LCD_B};
      if (!nRST) begin
         check("rst_adb", 32'(u_if.vram_adb), 0);
         check("rst_ceb", 32'(u_if.vram_ceb), 0);
         check("rst_font_addr", 32'(u_if.font_addr), 0);
         check("rst_de", 32'(u_if.LCD_DE), 0);
         check("rst_rgb", 32'(rgb), 0);
         check("rst_fs", 32'(u_if.frame_start), 0);
         check("rst_s_de", 32'(u_ifs.LCD_DE), 0);
         exp_adb = 0; run = 0; prev_de = 0;
         s_run = 0; s_lines = 0; s_prev_de = 0; last_fs_s = -1;
      end else begin
         c = n % FRAME;
         check("ceb", 32'(u_if.vram_ceb), 32'(m_act(c)));
         if (m_act(c)) exp_adb = m_addr(c);
         check("adb", 32'(u_if.vram_adb), 32'(exp_adb));
         check("frame_start", 32'(u_if.frame_start), 32'(c == 0));
         if (n >= 1 && m_act((n - 1) % FRAME))
            check("font_addr", 32'(u_if.font_addr), 32'(m_fa((n - 1) % FRAME)));
         if (n >= 3 && m_act((n - 3) % FRAME)) begin
            check("de", 32'(u_if.LCD_DE), 1);
            check("rgb", 32'(rgb), 32'(m_rgb((n - 3) % FRAME)));
         end else begin
            check("de", 32'(u_if.LCD_DE), 0);
            check("rgb_blank", 32'(rgb), 0);
         end
         if (u_if.LCD_DE) run++;
         else if (prev_de) begin
            check("de_run_len", 32'(run), 480);
            run = 0;
         end
         prev_de = u_if.LCD_DE;

         // Hand-computed pins of the model
         if (n == 1)     check("fs_single_cycle", 32'(u_if.frame_start), 0);
         if (n == 6415)  check("adb_x0_y0", 32'(u_if.vram_adb), 32'h200);
         if (n == 14919) check("adb_x8_y16", 32'(u_if.vram_adb), 32'h23D);
         if (n == 6417)  check("de_before_first", 32'(u_if.LCD_DE), 0);
         if (n == 6418)  check("de_first", 32'(u_if.LCD_DE), 1);
         if (n >= 6418 && n < 6426)
            check("glyph_px", 32'(rgb), 32'(glyph_exp[n - 6418]));

         // Shrunken-timing instance: 40x36 total, 32x32 active, constant 0xFF glyphs
         sc = n % SFRAME;
         if (u_ifs.LCD_DE) check("s_rgb_fg", 32'(srgb), 32'hF800);
         else              check("s_rgb_off", 32'(srgb), 0);
         if (sc == 1356) check("s_adb_last", 32'(u_ifs.vram_adb), 32'h207);
         if (u_ifs.LCD_DE) begin
            if (!s_prev_de) s_lines++;
            s_run++;
         end else if (s_prev_de) begin
            check("s_de_run_len", 32'(s_run), 32);
            s_run = 0;
         end
         s_prev_de = u_ifs.LCD_DE;
         if (u_ifs.frame_start) begin
            if (last_fs_s >= 0) begin
               check("s_frame_period", 32'(n - last_fs_s), 32'(SFRAME));
               check("s_de_lines", 32'(s_lines), 32);
            end
            last_fs_s = n;
            s_lines   = 0;
         end
      end
   end

   initial begin
      for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
      for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
      vram[13'h200] = 8'h06;
      for (int r = 0; r < 16; r++) font_mem[6 * 16 + r] = 8'hA5;

      nRST = 1'b0;
      repeat (10) @(negedge PixelClk);
      #1 nRST = 1'b1;

      // Run to stage-0 pixel x=200 of line 100, then reset mid-line
      repeat (59716) @(negedge PixelClk);
      check("de_before_midreset", 32'(u_if.LCD_DE), 1);
      #2 nRST = 1'b0;
      #1;
      check("midreset_de_async", 32'(u_if.LCD_DE), 0);
      check("midreset_rgb_async", 32'({u_if.LCD_R, u_if.LCD_G, u_if.LCD_B}), 0);
      check("midreset_ceb_async", 32'(u_if.vram_ceb), 0);

      repeat (10) @(negedge PixelClk);
      #1 nRST = 1'b1;
      repeat (6418 + 600) @(negedge PixelClk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
